cpu_ram_arbiter: RTL and testbench

//  Shares the single-port 1024x8 CPU_RAM block between two requesters:
//  the CPU data port (primary) and a DMA/message engine (secondary).

---
 rtl/cpu_ram_arbiter.sv | 110 +++++++++++
 tb/tb_cpu_ram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ram_arbiter.sv
// Arbitrates the single-port CPU_RAM between the CPU data port (fixed priority)
// and the DMA engine, with a starvation limit that forces a DMA slot.
module cpu_ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rdy,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rdy,
    output logic [DATA_WIDTH-1:0] dma_rdata,

    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int         NUM_PORTS  = 2;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]            wait_cnt_reg;
    logic [3:0]            wait_cnt_next;
    logic                  dma_forced;
    logic                  any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  ram_ce_reg;
    logic                  ram_we_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic [DATA_WIDTH-1:0] ram_data_reg;

    // Read-tag pipeline: stage 0 lines up with the RAM strobe, stage 1 with ram_q.
    logic [1:0]            rd_valid_reg;
    logic [1:0]            rd_dma_reg;
    logic [NUM_PORTS-1:0]  rdy_vec;

    always_comb begin
        dma_forced    = (wait_cnt_reg == WAIT_LIMIT);
        cpu_gnt       = !Reset && cpu_req && (!dma_req || !dma_forced);
        dma_gnt       = !Reset && dma_req && (!cpu_req || dma_forced);
        any_gnt       = cpu_gnt || dma_gnt;
        sel_we        = dma_gnt ? dma_we    : cpu_we;
        sel_addr      = dma_gnt ? dma_addr  : cpu_addr;
        sel_wdata     = dma_gnt ? dma_wdata : cpu_wdata;

        wait_cnt_next = '0;
        if (dma_req && !dma_gnt) begin
            wait_cnt_next = dma_forced ? wait_cnt_reg : wait_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt_reg <= '0;
            ram_ce_reg   <= 1'b0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_data_reg <= '0;
            rd_valid_reg <= '0;
            rd_dma_reg   <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            ram_ce_reg   <= any_gnt;
            ram_we_reg   <= any_gnt && sel_we;
            // Address/data hold their last value on idle cycles.
            if (any_gnt) begin
                ram_addr_reg <= sel_addr;
                ram_data_reg <= sel_wdata;
            end
            rd_valid_reg <= {rd_valid_reg[0], any_gnt && !sel_we};
            rd_dma_reg   <= {rd_dma_reg[0], dma_gnt};
        end
    end

    // Port 0 is the CPU, port 1 the DMA engine.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rdy
            assign rdy_vec[gi] = rd_valid_reg[1] && (rd_dma_reg[1] == (gi == 1));
        end
    endgenerate

    assign cpu_rdy   = rdy_vec[0];
    assign dma_rdy   = rdy_vec[1];
    assign cpu_rdata = ram_q;
    assign dma_rdata = ram_q;

    assign ram_ce    = ram_ce_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_data  = ram_data_reg;

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Scoreboard bench for cpu_ram_arbiter: a behavioural arbiter/memory model
// predicts grants, RAM strobes and read completions; a monitor checks them.
module tb_cpu_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MW = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rdy;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          dma_gnt, dma_rdy;
    logic [DW-1:0] dma_rdata;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q = '0;

    cpu_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdy(dma_rdy), .dma_rdata(dma_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_q(ram_q)
    );

    always #5 Clock = ~Clock;

    // Single-port RAM, registered read, normal write mode.
    logic [DW-1:0] mem [1024];
    always @(posedge Clock) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_data;
            else        ram_q <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    typedef struct {
        int            due;
        logic          ce;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } st_t;

    rd_t cq[$];
    rd_t dq[$];
    st_t sq[$];

    logic [DW-1:0] shadow [1024];
    int            mwait = 0;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d = '0;
    logic          exp_c = 1'b0, exp_d = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h required %0h", nm, cyc, got, exp);
        end
    endtask

    // One clock of stimulus; the reference model predicts everything it causes.
    task automatic step(input logic rst, input logic cr, input logic cw,
                        input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
        logic          ec, ed, gw;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        st_t           s;
        rd_t           r;
        @(posedge Clock);
        #1;
        Reset = rst;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        ec = 1'b0;
        ed = 1'b0;
        s.due = cyc + 1;
        if (rst) begin
            mwait = 0;
            while (cq.size() > 0 && cq[$].due > cyc) void'(cq.pop_back());
            while (dq.size() > 0 && dq[$].due > cyc) void'(dq.pop_back());
            last_a = '0;
            last_d = '0;
            s.ce = 1'b0; s.we = 1'b0; s.addr = '0; s.data = '0;
        end else begin
            if (cr && dr) begin
                ed = (mwait == MW);
                ec = !ed;
            end else begin
                ec = cr;
                ed = dr;
            end
            if (dr && !ed) mwait = (mwait < MW) ? mwait + 1 : MW;
            else           mwait = 0;
            if (ec || ed) begin
                gw = ed ? dw : cw;
                ga = ed ? da : ca;
                gd = ed ? dd : cd;
                if (gw) begin
                    shadow[ga] = gd;
                end else begin
                    r.due  = cyc + 2;
                    r.data = shadow[ga];
                    if (ed) dq.push_back(r);
                    else    cq.push_back(r);
                end
                last_a = ga;
                last_d = gd;
                s.ce = 1'b1; s.we = gw; s.addr = ga; s.data = gd;
            end else begin
                s.ce = 1'b0; s.we = 1'b0; s.addr = last_a; s.data = last_d;
            end
        end
        sq.push_back(s);
        exp_c = ec;
        exp_d = ed;
        @(negedge Clock);
        check("cpu_gnt", 32'(cpu_gnt), 32'(ec));
        check("dma_gnt", 32'(dma_gnt), 32'(ed));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic both(input logic [AW-1:0] ca, input logic [AW-1:0] da);
        step(1'b0, 1'b1, 1'b0, ca, '0, 1'b1, 1'b0, da, '0);
    endtask

    // Monitor: strobe and completion checks, decoupled from the stimulus.
    always @(negedge Clock) begin
        st_t s;
        rd_t r;
        if (sq.size() > 0 && sq[0].due == cyc) begin
            s = sq.pop_front();
            check("ram_ce",   32'(ram_ce),   32'(s.ce));
            check("ram_we",   32'(ram_we),   32'(s.we));
            check("ram_addr", 32'(ram_addr), 32'(s.addr));
            check("ram_data", 32'(ram_data), 32'(s.data));
        end
        if (cpu_rdy) begin
            if (cq.size() == 0 || cq[0].due != cyc) begin
                check("cpu_rdy_unexpected", 32'(cpu_rdy), 32'd0);
            end else begin
                r = cq.pop_front();
                check("cpu_rdata", 32'(cpu_rdata), 32'(r.data));
                $display("cpu read complete cycle %0d data %02h", cyc, cpu_rdata);
            end
        end else if (cq.size() > 0 && cq[0].due <= cyc) begin
            void'(cq.pop_front());
            check("cpu_rdy_missing", 32'(cpu_rdy), 32'd1);
        end
        if (dma_rdy) begin
            if (dq.size() == 0 || dq[0].due != cyc) begin
                check("dma_rdy_unexpected", 32'(dma_rdy), 32'd0);
            end else begin
                r = dq.pop_front();
                check("dma_rdata", 32'(dma_rdata), 32'(r.data));
                $display("dma read complete cycle %0d data %02h", cyc, dma_rdata);
            end
        end else if (dq.size() > 0 && dq[0].due <= cyc) begin
            void'(dq.pop_front());
            check("dma_rdy_missing", 32'(dma_rdy), 32'd1);
        end
    end

    initial begin
        logic          rst, prev_rst;
        logic          cr, cw, dr, dw;
        logic [AW-1:0] ca, da;
        logic [DW-1:0] cd, dd;
        logic [DW-1:0] v;

        for (int i = 0; i < 1024; i++) begin
            v = 8'($urandom);
            mem[i]    = v;
            shadow[i] = v;
        end

        repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        idle();

        // CPU write then read of the same address.
        step(1'b0, 1'b1, 1'b1, 10'h155, 8'hA5, 1'b0, 1'b0, '0, '0);
        idle();
        step(1'b0, 1'b1, 1'b0, 10'h155, '0, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // Both held high: C,C,C,D repeating.
        for (int k = 0; k < 12; k++) begin
            both(10'(k), 10'(k + 100));
            check("pattern_dma_gnt", 32'(dma_gnt), 32'((k % 4) == 3));
        end
        idle();
        idle();

        // DMA-only burst of reads.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'(k), '0);
        idle();
        idle();

        // Interleaved CPU and DMA reads after seeding the locations.
        step(1'b0, 1'b1, 1'b1, 10'h010, 8'h11, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 8'h22);
        step(1'b0, 1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, '0);
        idle();
        idle();

        // Reset right after a read grant: the read is dropped, CPU wins first after.
        both(10'h020, 10'h021);
        both(10'h020, 10'h021);
        step(1'b0, 1'b1, 1'b0, 10'h030, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        both(10'h040, 10'h041);
        check("post_reset_cpu_first", 32'(cpu_gnt), 32'd1);
        idle();
        idle();

        // A one-cycle gap in dma_req restarts the starvation count.
        both(10'h050, 10'h051);
        both(10'h050, 10'h051);
        step(1'b0, 1'b1, 1'b0, 10'h052, '0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            both(10'h053, 10'h054);
            check("restart_dma_gnt", 32'(dma_gnt), 32'(k == 3));
        end
        idle();
        idle();

        // Randomized traffic, honouring the hold-until-granted rule.
        prev_rst = 1'b0;
        cr = 1'b0; cw = 1'b0; ca = '0; cd = '0;
        dr = 1'b0; dw = 1'b0; da = '0; dd = '0;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!(cr && !exp_c) || prev_rst) begin
                cr = ($urandom_range(0, 9) < 6);
                cw = $urandom_range(0, 1) == 1;
                ca = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
                cd = 8'($urandom);
            end
            if (!(dr && !exp_d) || prev_rst) begin
                dr = ($urandom_range(0, 9) < 6);
                dw = $urandom_range(0, 1) == 1;
                da = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
                dd = 8'($urandom);
            end
            step(rst, cr, cw, ca, cd, dr, dw, da, dd);
            prev_rst = rst;
        end

        repeat (4) idle();
        check("pending_reads", 32'(cq.size() + dq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
